mips_fetch_queue: RTL and testbench

- Decoupling buffer directly downstream of the instruction fetch unit; captures each fetched {PC, IR} pair and presents it to the decode stage.
- Ready/valid handshake on both sides, so decode stalls do not freeze fetch until the queue is full.
- Pre-decodes control-transfer instructions at push time (beq/bne/j/jal/jr) so decode and hazard logic get a registered flag.
- Flush input discards all queued entries on a taken branch or jump.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mips_predecode.sv | 26 ++
 rtl/mips_fetch_queue.sv | 109 ++++++++++
 tb/tb_mips_fetch_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, default widths and the
// fetch-queue entry record.
package mips_pkg;

   localparam int PC_W_DEF   = 30;
   localparam int INST_W_DEF = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef struct packed {
      logic [PC_W_DEF-1:0]   pc;
      logic [INST_W_DEF-1:0] ir;
      logic                  is_ctrl;
   } fq_entry_t;

endpackage

// File: rtl/mips_predecode.sv
// Combinational control-transfer detector (beq/bne/j/jal/jr); shared with decode.
module mips_predecode
   import mips_pkg::*;
(
   input  logic [31:0] ir,
   output logic        is_ctrl
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_bits;

   assign opcode      = ir[31:26];
   assign funct       = ir[5:0];
   assign unused_bits = ^ir[25:6];

   always_comb begin
      is_ctrl = 1'b0;
      case (opcode)
         OP_BEQ, OP_BNE, OP_J, OP_JAL: is_ctrl = 1'b1;
         OP_RTYPE:                     is_ctrl = (funct == FN_JR);
         default:                      is_ctrl = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_fetch_queue.sv
// Fetch-to-decode decoupling FIFO with registered control-transfer pre-decode.
// Define MIPS_FETCHQ_BYPASS_EN for a zero-latency path through an empty queue.
module mips_fetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PC_W   = PC_W_DEF,
   parameter int INST_W = INST_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PC_W-1:0]          in_pc,
   input  logic [INST_W-1:0]        in_ir,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [INST_W-1:0]        out_ir,
   output logic [PC_W-1:0]          out_pc_plus1,
   output logic                     out_is_ctrl,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_idx, wr_idx;
   logic [PC_W-1:0]    pc_mem [DEPTH];
   logic [INST_W-1:0]  ir_mem [DEPTH];
   logic [DEPTH-1:0]   ctrl_mem;
   logic               empty, full, push, pop;
   logic               in_is_ctrl, bypass_hit, bypass_take;

   mips_predecode u_predecode (
      .ir      (in_ir[31:0]),
      .is_ctrl (in_is_ctrl)
   );

   assign rd_idx   = rd_ptr_q[AW-1:0];
   assign wr_idx   = wr_ptr_q[AW-1:0];
   assign empty    = (rd_ptr_q == wr_ptr_q);
   assign full     = (rd_idx == wr_idx) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
   assign in_ready = !full;
   assign count    = wr_ptr_q - rd_ptr_q;

`ifdef MIPS_FETCHQ_BYPASS_EN
   assign bypass_hit = empty && !flush && in_valid;
`else
   assign bypass_hit = 1'b0;
`endif
   // A bypassed beat that decode takes immediately never occupies a slot.
   assign bypass_take = bypass_hit && out_ready;
   assign push        = in_valid && in_ready && !flush && !bypass_take;
   assign pop         = !empty && out_ready && !flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_idx]   <= in_pc;
         ir_mem[wr_idx]   <= in_ir;
         ctrl_mem[wr_idx] <= in_is_ctrl;
      end
   end

   always_comb begin
      out_valid    = 1'b0;
      out_pc       = '0;
      out_ir       = '0;
      out_is_ctrl  = 1'b0;
      out_pc_plus1 = '0;
      if (!empty) begin
         out_valid   = 1'b1;
         out_pc      = pc_mem[rd_idx];
         out_ir      = ir_mem[rd_idx];
         out_is_ctrl = ctrl_mem[rd_idx];
      end else if (bypass_hit) begin
         out_valid   = 1'b1;
         out_pc      = in_pc;
         out_ir      = in_ir;
         out_is_ctrl = in_is_ctrl;
      end
      if (out_valid) out_pc_plus1 = out_pc + 1'b1;
   end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Self-checking bench for mips_fetch_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_mips_fetch_queue;
   import mips_pkg::*;

   localparam int DEPTH  = 4;
   localparam int PC_W   = 30;
   localparam int INST_W = 32;
   localparam int CW     = 3;
`ifdef MIPS_FETCHQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_ready, flush, out_valid, out_ready, out_is_ctrl;
   logic [PC_W-1:0]   in_pc, out_pc, out_pc_plus1;
   logic [INST_W-1:0] in_ir, out_ir;
   logic [CW-1:0]     count;

   int checks = 0;
   int passed = 0;
   fq_entry_t model_q[$];

   mips_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_ir(in_ir), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
      .out_pc_plus1(out_pc_plus1), .out_is_ctrl(out_is_ctrl), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Control transfers: j=2, jal=3, beq=4, bne=5, or R-type with funct 8 (jr).
   function automatic bit ref_ctrl(logic [31:0] ir);
      logic [5:0] op;
      op = ir[31:26];
      if (op == 6'd2 || op == 6'd3 || op == 6'd4 || op == 6'd5) return 1'b1;
      if (op == 6'd0 && ir[5:0] == 6'd8) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic model_check(string tag);
      logic            ev;
      logic [PC_W-1:0] epc, ep1;
      logic [31:0]     eir;
      ev = 1'b0; epc = '0; eir = '0;
      if (model_q.size() > 0) begin
         ev = 1'b1; epc = model_q[0].pc; eir = model_q[0].ir;
      end else if (BYP && in_valid && !flush) begin
         ev = 1'b1; epc = in_pc; eir = in_ir;
      end
      ep1 = ev ? epc + 1'b1 : '0;
      chk({tag, ".valid"}, out_valid, ev);
      chk({tag, ".pc"}, out_pc, epc);
      chk({tag, ".ir"}, out_ir, eir);
      chk({tag, ".pc_plus1"}, out_pc_plus1, ep1);
      chk({tag, ".is_ctrl"}, out_is_ctrl, ev ? ref_ctrl(eir) : 1'b0);
      chk({tag, ".count"}, count, model_q.size());
      chk({tag, ".in_ready"}, in_ready, model_q.size() < DEPTH);
   endtask

   // Called at posedge+1; checks pre-edge outputs, clocks, then advances the model.
   task automatic run_cycle(string tag, logic iv, logic [PC_W-1:0] pc, logic [31:0] ir,
                            logic ordy, logic fl);
      int n;
      bit do_pop, do_push, take;
      in_valid = iv; in_pc = pc; in_ir = ir; out_ready = ordy; flush = fl;
      #2;
      model_check(tag);
      n       = model_q.size();
      take    = BYP && n == 0 && iv && ordy && !fl;
      do_pop  = n > 0 && ordy && !fl;
      do_push = iv && n < DEPTH && !fl && !take;
      @(posedge clk);
      #1;
      if (fl) model_q.delete();
      else begin
         if (do_pop) void'(model_q.pop_front());
         if (do_push) model_q.push_back('{pc: pc, ir: ir, is_ctrl: ref_ctrl(ir)});
      end
      $display("cycle %s: in_v=%0b pc=%0h ir=%08h ordy=%0b flush=%0b -> count=%0d",
               tag, iv, pc, ir, ordy, fl, count);
   endtask

   typedef struct {
      logic            iv;
      logic [PC_W-1:0] pc;
      logic [31:0]     ir;
      logic            ordy;
      logic            e_v;
      logic [PC_W-1:0] e_pc;
      logic [PC_W-1:0] e_p1;
      logic            e_ctrl;
      logic [CW-1:0]   e_cnt;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [31:0] rir;
      logic [5:0]  ops[7];

      vecs[0] = '{1'b1, 30'h10,       32'h0800_0004, 1'b0, 1'b1, 30'h10,       30'h11, 1'b1, 3'd1};
      vecs[1] = '{1'b0, 30'h0,        32'h0,         1'b1, 1'b0, 30'h0,        30'h0,  1'b0, 3'd0};
      vecs[2] = '{1'b1, 30'h20,       32'h03E0_0008, 1'b0, 1'b1, 30'h20,       30'h21, 1'b1, 3'd1};
      vecs[3] = '{1'b1, 30'h21,       32'h0000_0020, 1'b1, 1'b1, 30'h21,       30'h22, 1'b0, 3'd1};
      vecs[4] = '{1'b1, 30'h22,       32'h1000_FFFF, 1'b1, 1'b1, 30'h22,       30'h23, 1'b1, 3'd1};
      vecs[5] = '{1'b1, 30'h3FFFFFFF, 32'h0000_0000, 1'b1, 1'b1, 30'h3FFFFFFF, 30'h0,  1'b0, 3'd1};
      vecs[6] = '{1'b0, 30'h0,        32'h0,         1'b1, 1'b0, 30'h0,        30'h0,  1'b0, 3'd0};

      reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_ir = '0; flush = 1'b0; out_ready = 1'b0;
      #3;
      chk("reset.count", count, 0);
      chk("reset.out_valid", out_valid, 0);
      chk("reset.in_ready", in_ready, 1);
      chk("reset.out_pc", out_pc, 0);
      #9 reset = 1'b0;
      @(posedge clk); #1;

      // Vector table: push/pop pattern, expected head after the edge.
      for (int i = 0; i < 7; i++) begin
         run_cycle("vec", vecs[i].iv, vecs[i].pc, vecs[i].ir, vecs[i].ordy, 1'b0);
         in_valid = 1'b0;
         #1;
         chk("vec.out_valid", out_valid, vecs[i].e_v);
         chk("vec.out_pc", out_pc, vecs[i].e_pc);
         chk("vec.out_pc_plus1", out_pc_plus1, vecs[i].e_p1);
         chk("vec.out_is_ctrl", out_is_ctrl, vecs[i].e_ctrl);
         chk("vec.count", count, vecs[i].e_cnt);
      end

      // Fill to full, reject a fifth beat, then drain in order.
      for (int i = 0; i < 4; i++) run_cycle("fill", 1'b1, PC_W'(i), 32'h0000_0020, 1'b0, 1'b0);
      chk("full.count", count, 4);
      chk("full.in_ready", in_ready, 0);
      run_cycle("fill5", 1'b1, 30'd4, 32'h0000_0020, 1'b0, 1'b0);
      chk("full5.count", count, 4);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b0; out_ready = 1'b1;
         #2;
         chk("drain.pc", out_pc, i);
         run_cycle("drain", 1'b0, '0, '0, 1'b1, 1'b0);
      end
      chk("drain.out_valid", out_valid, 0);

      // Streaming push+pop across pointer wrap.
      run_cycle("stream", 1'b1, 30'd0, 32'h0000_0020, 1'b0, 1'b0);
      for (int i = 1; i < 10; i++) begin
         run_cycle("stream", 1'b1, PC_W'(i), 32'h0000_0020, 1'b1, 1'b0);
         chk("stream.count", count, 1);
         chk("stream.pc", out_pc, i);
      end
      run_cycle("stream", 1'b0, '0, '0, 1'b1, 1'b0);

      // Flush with a simultaneous push.
      for (int i = 0; i < 3; i++) run_cycle("pref", 1'b1, PC_W'(i + 8), 32'h0000_0020, 1'b0, 1'b0);
      run_cycle("flush", 1'b1, 30'h20, 32'h0000_0020, 1'b0, 1'b1);
      in_valid = 1'b0; flush = 1'b0;
      #1;
      chk("flush.count", count, 0);
      chk("flush.out_valid", out_valid, 0);
      run_cycle("postflush", 1'b0, '0, '0, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle with two entries queued.
      run_cycle("pre_rst", 1'b1, 30'h40, 32'h0800_0000, 1'b0, 1'b0);
      run_cycle("pre_rst", 1'b1, 30'h41, 32'h0000_0020, 1'b0, 1'b0);
      chk("pre_rst.count", count, 2);
      in_valid = 1'b0;
      #3 reset = 1'b1;
      #1;
      chk("async_rst.out_valid", out_valid, 0);
      chk("async_rst.count", count, 0);
      model_q.delete();
      #2 reset = 1'b0;
      @(posedge clk); #1;

`ifdef MIPS_FETCHQ_BYPASS_EN
      in_valid = 1'b1; in_pc = 30'h55; in_ir = 32'h0800_0001; out_ready = 1'b1;
      #1;
      chk("bypass.out_valid", out_valid, 1);
      chk("bypass.out_pc", out_pc, 30'h55);
      run_cycle("bypass", 1'b1, 30'h55, 32'h0800_0001, 1'b1, 1'b0);
      in_valid = 1'b0;
      #1;
      chk("bypass.count", count, 0);
`endif

      // Randomized traffic against the reference queue.
      ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd35};
      for (int i = 0; i < 400; i++) begin
         rir = $urandom;
         rir[31:26] = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 1) == 0) rir[5:0] = 6'd8;
         run_cycle("rand", $urandom_range(0, 3) != 0, PC_W'($urandom), rir,
                   1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
